// File: rtl/iterative_normalizer_if.sv
// Handshake bundle for iterative_normalizer.
//   Input side : in_data, mode, in_valid (to block), in_ready (from block)
//   Output side: out_data, shift_count, zero, out_valid (from block), out_ready (to block)
//   slave modport  : the normalizer itself
//   master modport : whoever feeds words in and consumes results
interface iterative_normalizer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
);
  logic [WIDTH-1:0] in_data;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] shift_count;
  logic             zero;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data, mode, in_valid, out_ready,
    output in_ready, out_data, shift_count, zero, out_valid
  );

  modport master (
    output in_data, mode, in_valid, out_ready,
    input  in_ready, out_data, shift_count, zero, out_valid
  );
endinterface

// File: rtl/iterative_normalizer.sv
// Iterative normalizer: finds the shift amount a barrel shifter would need.
// A captured word is shifted one position per cycle until the selected
// normalization condition holds; the result word and shift count are then
// held until the consumer accepts them.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of iterative_normalizer_if
//              mode 00 pass, 01 left-unsigned, 10 right-trailing, 11 left-signed
//
// state   | meaning
// IDLE    | waiting for in_valid; in_ready high
// SHIFT   | testing/shifting the work register, one position per cycle
// DONE    | result presented with out_valid; waiting for out_ready
module iterative_normalizer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic               clk,
  input logic               rst,
  iterative_normalizer_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] MODE_PASS    = 2'b00;
  localparam logic [1:0] MODE_LEFT_U  = 2'b01;
  localparam logic [1:0] MODE_RIGHT_T = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] shift_count_q, shift_count_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic             work_zero, work_ones;
  logic [WIDTH-1:0] shift_l, shift_r;
  logic             stop;
  logic [WIDTH-1:0] res_data;
  logic [CNT_W-1:0] res_cnt;

  assign work_zero = (work_q == '0);
  assign work_ones = (work_q == '1);
  assign shift_l   = {work_q[WIDTH-2:0], 1'b0};
  assign shift_r   = {1'b0, work_q[WIDTH-1:1]};

  // Stop test on the current work word. All-zero words (and all-ones in
  // signed mode) would never satisfy the condition by shifting, so their
  // final result is produced directly on the first test.
  always_comb begin
    stop     = 1'b0;
    res_data = work_q;
    res_cnt  = cnt_q;
    case (mode_q)
      MODE_PASS: stop = 1'b1;
      MODE_LEFT_U: begin
        if (work_zero) begin
          stop    = 1'b1;
          res_cnt = CNT_W'(WIDTH);
        end else if (work_q[WIDTH-1]) begin
          stop = 1'b1;
        end
      end
      MODE_RIGHT_T: begin
        if (work_zero) begin
          stop    = 1'b1;
          res_cnt = CNT_W'(WIDTH);
        end else if (work_q[0]) begin
          stop = 1'b1;
        end
      end
      default: begin
        if (work_zero) begin
          stop    = 1'b1;
          res_cnt = CNT_W'(WIDTH - 1);
        end else if (work_ones) begin
          stop     = 1'b1;
          res_data = {1'b1, {(WIDTH-1){1'b0}}};
          res_cnt  = CNT_W'(WIDTH - 1);
        end else if (work_q[WIDTH-1] != work_q[WIDTH-2]) begin
          stop = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    work_d        = work_q;
    mode_d        = mode_q;
    cnt_d         = cnt_q;
    out_data_d    = out_data_q;
    shift_count_d = shift_count_q;
    zero_d        = zero_q;
    out_valid_d   = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.in_data;
          mode_d  = bus.mode;
          cnt_d   = '0;
          zero_d  = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (stop) begin
          out_data_d    = res_data;
          shift_count_d = res_cnt;
          // A nonzero word never shifts down to zero, so this reflects the captured word.
          zero_d        = work_zero;
          out_valid_d   = 1'b1;
          state_d       = S_DONE;
        end else begin
          work_d = (mode_q == MODE_RIGHT_T) ? shift_r : shift_l;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      work_q        <= '0;
      mode_q        <= '0;
      cnt_q         <= '0;
      out_data_q    <= '0;
      shift_count_q <= '0;
      zero_q        <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      mode_q        <= mode_d;
      cnt_q         <= cnt_d;
      out_data_q    <= out_data_d;
      shift_count_q <= shift_count_d;
      zero_q        <= zero_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_data    = out_data_q;
  assign bus.shift_count = shift_count_q;
  assign bus.zero        = zero_q;
  assign bus.out_valid   = out_valid_q;

endmodule

// File: tb/tb_iterative_normalizer.sv
module tb_iterative_normalizer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iterative_normalizer_if #(.WIDTH(8)) bus ();
  iterative_normalizer #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0] data;
    int         cnt;
    logic       zero;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: count leading zeros / trailing zeros / redundant sign bits directly.
  function automatic exp_t model(input logic [1:0] m, input logic [7:0] d);
    exp_t e;
    int n;
    e.zero = (d == 8'h00);
    e.data = d;
    e.cnt  = 0;
    e.lat  = 1;
    n = 0;
    case (m)
      2'b00: ;
      2'b01: begin
        if (d == 8'h00) e.cnt = 8;
        else begin
          while (d[7-n] == 1'b0) n++;
          e.cnt = n; e.data = d << n; e.lat = n + 1;
        end
      end
      2'b10: begin
        if (d == 8'h00) e.cnt = 8;
        else begin
          while (d[n] == 1'b0) n++;
          e.cnt = n; e.data = d >> n; e.lat = n + 1;
        end
      end
      default: begin
        if (d == 8'h00) e.cnt = 7;
        else if (d == 8'hFF) begin e.cnt = 7; e.data = 8'h80; end
        else begin
          while (n < 6 && d[7-n] == d[6-n]) n++;
          e.cnt = n; e.data = d << n; e.lat = n + 1;
        end
      end
    endcase
    return e;
  endfunction

  task automatic run_op(input logic [1:0] m, input logic [7:0] d, input bit hold);
    exp_t e;
    exp_t got;
    int lat;
    string tag;
    tag = $sformatf("m%0d_d%02h", m, d);
    sb.push_back(model(m, d));
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_data  = d;
    bus.mode     = m;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    bus.mode     = 2'($urandom);
    // out_ready raised outside DONE must be ignored
    bus.out_ready = 1'b1;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) bus.out_ready = 1'b0;
    end
    bus.out_ready = 1'b0;
    e = sb[0];
    chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk({tag, "_out_data"}, 32'(bus.out_data), 32'(got.data));
      chk({tag, "_shift_count"}, 32'(bus.shift_count), 32'(got.cnt));
      chk({tag, "_zero"}, 32'(bus.zero), 32'(got.zero));
      if (hold) begin
        for (int i = 0; i < 10; i++) begin
          bus.in_valid = 1'b1;
          bus.in_data  = 8'h01;
          bus.mode     = 2'b01;
          @(posedge clk); #1;
          chk({tag, "_bp_out_valid"}, 32'(bus.out_valid), 32'd1);
          chk({tag, "_bp_in_ready"}, 32'(bus.in_ready), 32'd0);
          chk({tag, "_bp_out_data"}, 32'(bus.out_data), 32'(got.data));
          chk({tag, "_bp_shift_count"}, 32'(bus.shift_count), 32'(got.cnt));
        end
        bus.in_valid = 1'b0;
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_hs_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_hs_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_data   = '0;
    bus.mode      = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_shift_count", 32'(bus.shift_count), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(2'b01, 8'h10, 1'b0);
    run_op(2'b10, 8'h58, 1'b0);
    run_op(2'b00, 8'h3C, 1'b0);
    run_op(2'b11, 8'hF2, 1'b0);
    run_op(2'b11, 8'h40, 1'b0);
    run_op(2'b11, 8'hFF, 1'b0);
    run_op(2'b01, 8'h00, 1'b0);
    run_op(2'b11, 8'h00, 1'b0);
    run_op(2'b00, 8'h00, 1'b0);
    run_op(2'b10, 8'h00, 1'b0);
    run_op(2'b10, 8'h80, 1'b0);
    run_op(2'b11, 8'h01, 1'b0);
    run_op(2'b11, 8'hC0, 1'b0);
    run_op(2'b01, 8'h10, 1'b1);

    // Abort mid-shift with an asynchronous reset between edges.
    bus.in_data  = 8'h01;
    bus.mode     = 2'b01;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_data", 32'(bus.out_data), 32'd0);
    chk("arst_shift_count", 32'(bus.shift_count), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_no_result", 32'(bus.out_valid), 32'd0);
    run_op(2'b01, 8'h01, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iterative_normalizer.md
Name: iterative_normalizer

Overview:
- Multi-cycle inverse of the barrel shifter: the shifter applies a given shift amount, this block finds it.
- Shifts a captured word one bit per cycle until a normalization condition holds, then reports the normalized word and the number of positions shifted.
- Used ahead of the barrel shifter and in fixed-point datapaths.
- Valid/ready handshake on both input and output.

Parameters:
- WIDTH, 8, data width in bits (>= 2).
- CNT_W, $clog2(WIDTH)+1, width of shift_count; must hold the value WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  word to normalize.
- mode  input  2  00 pass, 01 left-unsigned, 10 right-trailing, 11 left-signed.
- in_valid  input  1  in_data/mode valid.
- in_ready  output  1  block can accept (high only in IDLE).
- out_data  output  WIDTH  normalized word.
- shift_count  output  CNT_W  positions shifted.
- zero  output  1  captured word was all zeros.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - out_data = 0, shift_count = 0, zero = 0, out_valid = 0.
  - in_ready = 1, since it is decoded from state == IDLE.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: capture in_data into the work register, capture mode, clear the count, clear zero, go to SHIFT.
  - in_valid = 0: stay in IDLE.
- SHIFT (in_ready = 0, out_valid = 0). Each edge, test the current work register:
  - mode 00: stop immediately, count 0.
  - mode 01: stop if bit[WIDTH-1] = 1; else shift left by 1 with 0 fill, count += 1.
  - mode 10: stop if bit[0] = 1; else shift right by 1 with 0 fill, count += 1.
  - mode 11: stop if bit[WIDTH-1] != bit[WIDTH-2]; else shift left by 1 with 0 fill, count += 1.
  - On stop: load out_data and shift_count, set out_valid = 1, go to DONE.
- Degenerate inputs are tested on the first SHIFT edge and finish in one SHIFT cycle:
  - mode 01 or 10 with word 0: out_data = 0, shift_count = WIDTH, zero = 1.
  - mode 11 with all zeros: out_data = 0, shift_count = WIDTH-1, zero = 1.
  - mode 11 with all ones: out_data = 1 followed by zeros (0x80 at WIDTH 8), shift_count = WIDTH-1, zero = 0.
  - zero = 1 for any mode when the captured word is 0, including mode 00.
- Latency, with the capture at edge N:
  - Normal case: SHIFT occupies edges N+1 through N+count+1; out_valid is high after edge N+count+1.
  - Degenerate and mode 00: out_valid is high after edge N+1.
  - Maximum non-degenerate count is WIDTH-1 (modes 01/10) or WIDTH-2 (mode 11).
- DONE:
  - out_valid = 1; out_data, shift_count and zero held stable.
  - On an edge with out_ready = 1: clear out_valid, go to IDLE. in_ready is high the following cycle; there is no same-cycle bypass.
  - out_ready = 0: hold indefinitely.
- in_valid outside IDLE is ignored, and in_data/mode changes do not affect an operation in flight.
- out_ready outside DONE is ignored.
- Reset asserted in any state aborts the operation; no result is produced.
- Stored results are never overwritten before the handshake completes.

Test Plan:
- Left-unsigned: mode 01, in_data 0x10 captured at edge N -> out_data 0x80, shift_count 3, zero 0, out_valid high after N+4.
- Right-trailing and pass:
  - mode 10, 0x58 -> out_data 0x0B, shift_count 3.
  - mode 00, 0x3C -> out_data 0x3C, shift_count 0, out_valid after N+1.
- Left-signed:
  - mode 11, 0xF2 -> out_data 0x90, shift_count 3.
  - mode 11, 0x40 -> out_data 0x40, shift_count 0.
  - mode 11, 0xFF -> out_data 0x80, shift_count 7, zero 0.
- Zero input:
  - mode 01, 0x00 -> out_data 0x00, shift_count 8, zero 1, out_valid after N+1.
  - mode 11, 0x00 -> out_data 0x00, shift_count 7, zero 1.
- Back-pressure:
  - Hold out_ready = 0 for 10 cycles in DONE -> outputs constant, in_ready = 0, in_valid pulses with 0x01 are ignored.
  - Raise out_ready -> out_valid drops and in_ready is 1 on the next cycle.
- Async reset:
  - Assert rst mid-SHIFT (mode 01, 0x01) between clock edges -> out_valid = 0, out_data = 0, shift_count = 0, in_ready = 1 immediately.
  - After release, a new 0x01 yields shift_count 7.
